dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port data memory (ports dataOut, address, dataIn, writeEnable, clk).
- Port A is the CPU load/store unit; port B is the program/data loader used by test harnesses.
- Grants one request at a time with round-robin fairness and drives the memory for exactly one access cycle.
- Returns read data, or a write acknowledge, on a registered response.

Parameters:
- ADDR_WIDTH, 32, width of the request and memory address.
- DATA_WIDTH, 32, width of the data paths.
- DEPTH, 1024, number of valid memory words; addresses >= DEPTH are out of range.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- aReqValid  input  1  port A request valid.
- aReqReady  output  1  port A request accepted when valid & ready at posedge.
- aReqWrite  input  1  port A: 1 = write, 0 = read.
- aReqAddr  input  ADDR_WIDTH  port A address.
- aReqData  input  DATA_WIDTH  port A write data.
- aRspValid  output  1  port A response pulse, one cycle.
- aRspData  output  DATA_WIDTH  port A read data; 0 for writes and errors.
- aRspError  output  1  port A address out of range; qualified by aRspValid.
- bReqValid, bReqReady, bReqWrite, bReqAddr, bReqData, bRspValid, bRspData, bRspError: identical to the A ports, for port B.
- memAddress  output  ADDR_WIDTH  drives the memory address.
- memDataIn  output  DATA_WIDTH  drives the memory dataIn.
- memWriteEnable  output  1  drives the memory writeEnable.
- memDataOut  input  DATA_WIDTH  memory dataOut; read combinationally during ACCESS.

Behaviour:
- Reset (reset_n low, async):
  - state = IDLE; lastGrant = B, so A wins the first tie.
  - All rsp outputs 0; memWriteEnable 0; memAddress 0; memDataIn 0.
  - Any in-flight access is abandoned and no response is issued.
- FSM states: IDLE, ACCESS, RESPOND.
- IDLE:
  - xReqReady = 1 only for the port selected by arbitration; the other port's ready = 0.
  - Arbitration: only one port valid -> that port. Both valid -> the port not equal to lastGrant.
  - On a posedge with selected valid & ready: latch write, addr, data and the granted port id; set lastGrant; go to ACCESS.
  - No valid request -> stay in IDLE; ready still reflects the arbitration choice.
- ACCESS (exactly one cycle):
  - memAddress = latched addr; memDataIn = latched data.
  - memWriteEnable = latched write & (addr < DEPTH). Out-of-range writes never reach memory.
  - At the closing posedge, for an in-range read, capture memDataOut into the response data register.
  - Go to RESPOND.
- RESPOND (exactly one cycle):
  - Granted port's RspValid = 1.
  - RspData = captured data (reads) or 0 (writes, errors).
  - RspError = (addr >= DEPTH).
  - memWriteEnable = 0. Ungranted port's rsp outputs stay 0.
  - Return to IDLE.
- Outside ACCESS: memWriteEnable = 0; memAddress and memDataIn hold their last values.
- Timing:
  - Latency: acceptance edge E0, memory access in cycle E0..E1, RspValid high in cycle E1..E2.
  - Throughput: one access per 3 cycles.
  - Ready deasserts in ACCESS and RESPOND; requesters hold valid and payload until accepted.
- Fairness: with both ports continuously valid, grants strictly alternate A, B, A, B. A requester waits at most one other access.
- Out-of-range check compares the full ADDR_WIDTH address, unsigned, against DEPTH. Address DEPTH-1 is valid; DEPTH is an error.
- Ready/valid are sampled only at posedge in IDLE. Request inputs that change during ACCESS or RESPOND are ignored.

Test Plan:
- Reset: hold reset_n low, toggle clk -> all rsp outputs 0, memWriteEnable 0, aReqReady 1 (A favored). Release reset with no requests -> state IDLE, no rsp pulses.
- Port A write then read: write 42 to address 0, then read address 0.
  - Write -> memWriteEnable high for exactly one cycle, aRspValid one cycle later with aRspData 0.
  - Read -> aRspValid with aRspData 42, aRspError 0, 2 cycles after acceptance.
- Simultaneous requests: A writes 48 to address 1 and B reads address 0 (holding 42), both valid at the same edge.
  - A is granted first; B is granted on the next IDLE.
  - bRspData = 42; then a read of address 1 returns 48.
- Fairness: both ports continuously request for 6 grants -> grant order A,B,A,B,A,B. Each rsp goes only to its own port.
- Out of range: B writes 7 to address DEPTH -> memWriteEnable never asserted, bRspError 1, bRspData 0. A read of address DEPTH-1 afterwards returns the prior value with error 0.
- Reset mid-operation: assert reset_n low during ACCESS of a write -> no RspValid is issued, FSM returns to IDLE. The write must not commit if reset arrives before the ACCESS-closing edge.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and sequencer in front of a
// single-port data memory. Each granted request takes exactly three cycles:
// IDLE (accept), ACCESS (one memory cycle), RESPOND (one-cycle response pulse).
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   aReq*/aRsp*              port A (CPU load/store) request/response
//   bReq*/bRsp*              port B (loader) request/response
//   memAddress, memDataIn,   memory address, write data and write enable
//   memWriteEnable
//   memDataOut               memory read data, sampled at the end of ACCESS
module dmem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  aReqValid,
    output logic                  aReqReady,
    input  logic                  aReqWrite,
    input  logic [ADDR_WIDTH-1:0] aReqAddr,
    input  logic [DATA_WIDTH-1:0] aReqData,
    output logic                  aRspValid,
    output logic [DATA_WIDTH-1:0] aRspData,
    output logic                  aRspError,

    input  logic                  bReqValid,
    output logic                  bReqReady,
    input  logic                  bReqWrite,
    input  logic [ADDR_WIDTH-1:0] bReqAddr,
    input  logic [DATA_WIDTH-1:0] bReqData,
    output logic                  bRspValid,
    output logic [DATA_WIDTH-1:0] bRspData,
    output logic                  bRspError,

    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic [DATA_WIDTH-1:0] memDataIn,
    output logic                  memWriteEnable,
    input  logic [DATA_WIDTH-1:0] memDataOut
);

    typedef enum logic [1:0] {StIdle, StAccess, StRespond} state_e;

    localparam logic [ADDR_WIDTH-1:0] DepthAddr = ADDR_WIDTH'(DEPTH);

    state_e                state_q, state_d;
    logic                  last_grant_q;  // 1 = port B was granted last
    logic                  grant_q;       // 1 = current access belongs to port B
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;

    logic sel_b;
    logic sel_valid;
    logic accept;
    logic in_range;
    logic rsp_active;

    assign in_range = (addr_q < DepthAddr);

    // Lone requester wins; on a tie (both or neither valid) the port that
    // was not granted last is selected, so ready is stable while idle.
    always_comb begin
        sel_b = ~last_grant_q;
        if (aReqValid != bReqValid) begin
            sel_b = bReqValid;
        end
    end

    assign sel_valid = sel_b ? bReqValid : aReqValid;
    assign accept    = (state_q == StIdle) && sel_valid;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (accept) state_d = StAccess;
            StAccess:  state_d = StRespond;
            StRespond: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            rsp_data_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                grant_q      <= sel_b;
                last_grant_q <= sel_b;
                write_q      <= sel_b ? bReqWrite : aReqWrite;
                addr_q       <= sel_b ? bReqAddr  : aReqAddr;
                data_q       <= sel_b ? bReqData  : aReqData;
            end
            if (state_q == StAccess) begin
                rsp_data_q <= (!write_q && in_range) ? memDataOut : '0;
            end
        end
    end

    // Latched request registers drive the memory directly, so address and
    // data hold their last values outside ACCESS.
    assign memAddress     = addr_q;
    assign memDataIn      = data_q;
    assign memWriteEnable = (state_q == StAccess) && write_q && in_range;

    assign aReqReady = (state_q == StIdle) && !sel_b;
    assign bReqReady = (state_q == StIdle) &&  sel_b;

    assign rsp_active = (state_q == StRespond);

    assign aRspValid = rsp_active && !grant_q;
    assign aRspData  = aRspValid ? rsp_data_q : '0;
    assign aRspError = aRspValid && !in_range;

    assign bRspValid = rsp_active && grant_q;
    assign bRspData  = bRspValid ? rsp_data_q : '0;
    assign bRspError = bRspValid && !in_range;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a behavioural
// single-port memory attached to the mem* ports.
module tb_dmem_arbiter;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 1024;

    logic          clk;
    logic          reset_n;
    logic          aReqValid, aReqReady, aReqWrite;
    logic [AW-1:0] aReqAddr;
    logic [DW-1:0] aReqData;
    logic          aRspValid, aRspError;
    logic [DW-1:0] aRspData;
    logic          bReqValid, bReqReady, bReqWrite;
    logic [AW-1:0] bReqAddr;
    logic [DW-1:0] bReqData;
    logic          bRspValid, bRspError;
    logic [DW-1:0] bRspData;
    logic [AW-1:0] memAddress;
    logic [DW-1:0] memDataIn;
    logic          memWriteEnable;
    logic [DW-1:0] memDataOut;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mem [0:DEPTH-1];

    dmem_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .aReqValid     (aReqValid),
        .aReqReady     (aReqReady),
        .aReqWrite     (aReqWrite),
        .aReqAddr      (aReqAddr),
        .aReqData      (aReqData),
        .aRspValid     (aRspValid),
        .aRspData      (aRspData),
        .aRspError     (aRspError),
        .bReqValid     (bReqValid),
        .bReqReady     (bReqReady),
        .bReqWrite     (bReqWrite),
        .bReqAddr      (bReqAddr),
        .bReqData      (bReqData),
        .bRspValid     (bRspValid),
        .bRspData      (bRspData),
        .bRspError     (bRspError),
        .memAddress    (memAddress),
        .memDataIn     (memDataIn),
        .memWriteEnable(memWriteEnable),
        .memDataOut    (memDataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Out-of-range reads return a poison value so a leaked read shows up.
    assign memDataOut = (memAddress < DEPTH) ? mem[memAddress[9:0]] : 32'hdead_beef;

    always @(posedge clk) begin
        if (memWriteEnable && (memAddress < DEPTH)) mem[memAddress[9:0]] <= memDataIn;
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit pb, input bit wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data);
        if (pb) begin
            bReqValid = 1'b1; bReqWrite = wr; bReqAddr = addr; bReqData = data;
        end else begin
            aReqValid = 1'b1; aReqWrite = wr; aReqAddr = addr; aReqData = data;
        end
    endtask

    // Runs one full transaction from IDLE with requests already driven.
    // Returns #1 after the edge that brings the FSM back to IDLE.
    task automatic txn(input bit pb, input bit wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                       input bit err, input logic [1:0] drop);
        logic own_v, oth_v, own_e, oth_e;
        logic [DW-1:0] own_d, oth_d;
        #1;
        chk("idle_a_ready", aReqReady, !pb);
        chk("idle_b_ready", bReqReady, pb);
        @(posedge clk); #1;
        if (drop[0]) aReqValid = 1'b0;
        if (drop[1]) bReqValid = 1'b0;
        chk("acc_a_ready", aReqReady, 1'b0);
        chk("acc_b_ready", bReqReady, 1'b0);
        chk("acc_mem_addr", memAddress, addr);
        chk("acc_mem_din", memDataIn, wdata);
        chk("acc_mem_we", memWriteEnable, wr && !err);
        chk("acc_no_rsp", aRspValid | bRspValid, 1'b0);
        @(posedge clk); #1;
        own_v = pb ? bRspValid : aRspValid;
        own_d = pb ? bRspData  : aRspData;
        own_e = pb ? bRspError : aRspError;
        oth_v = pb ? aRspValid : bRspValid;
        oth_d = pb ? aRspData  : bRspData;
        oth_e = pb ? aRspError : bRspError;
        chk("rsp_valid", own_v, 1'b1);
        chk("rsp_data", own_d, rdata);
        chk("rsp_error", own_e, err);
        chk("rsp_other_quiet", {oth_v, oth_e}, 2'b00);
        chk("rsp_other_data", oth_d, '0);
        chk("rsp_mem_we", memWriteEnable, 1'b0);
        if (wr && !err) chk("mem_written", mem[addr[9:0]], wdata);
        @(posedge clk); #1;
        chk("rsp_pulse_end", aRspValid | bRspValid, 1'b0);
    endtask

    initial begin
        reset_n   = 1'b0;
        aReqValid = 1'b0; aReqWrite = 1'b0; aReqAddr = '0; aReqData = '0;
        bReqValid = 1'b0; bReqWrite = 1'b0; bReqAddr = '0; bReqData = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_rsp", {aRspValid, aRspError}, 2'b00);
        chk("rst_b_rsp", {bRspValid, bRspError}, 2'b00);
        chk("rst_a_data", aRspData, '0);
        chk("rst_b_data", bRspData, '0);
        chk("rst_mem_we", memWriteEnable, 1'b0);
        chk("rst_mem_addr", memAddress, '0);
        chk("rst_mem_din", memDataIn, '0);
        chk("rst_a_ready", aReqReady, 1'b1);
        chk("rst_b_ready", bReqReady, 1'b0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_no_rsp", aRspValid | bRspValid, 1'b0);
        chk("idle_a_ready_post", aReqReady, 1'b1);

        // Port A write 42 to 0, then read back
        drive(0, 1, 0, 42);
        txn(0, 1, 0, 42, 0, 0, 2'b01);
        drive(0, 0, 0, 0);
        txn(0, 0, 0, 0, 42, 0, 2'b01);

        // B alone reads 0; leaves lastGrant = B so A wins the next tie
        drive(1, 0, 0, 0);
        txn(1, 0, 0, 0, 42, 0, 2'b10);

        // Simultaneous: A writes 48 to 1, B reads 0
        drive(0, 1, 1, 48);
        drive(1, 0, 0, 0);
        txn(0, 1, 1, 48, 0, 0, 2'b01);
        txn(1, 0, 0, 0, 42, 0, 2'b10);
        drive(1, 0, 1, 0);
        txn(1, 0, 1, 0, 48, 0, 2'b10);

        // Fairness: both ports continuously valid for six grants
        drive(0, 0, 0, 0);
        drive(1, 0, 1, 0);
        for (int k = 0; k < 6; k++) begin
            txn(k[0], 0, k[0] ? 32'd1 : 32'd0, 0, k[0] ? 32'd48 : 32'd42, 0,
                (k == 5) ? 2'b11 : 2'b00);
        end

        // Boundary: DEPTH-1 is valid, DEPTH is an error for write and read
        drive(0, 1, DEPTH - 1, 32'h5a);
        txn(0, 1, DEPTH - 1, 32'h5a, 0, 0, 2'b01);
        drive(1, 1, DEPTH, 7);
        txn(1, 1, DEPTH, 7, 0, 1, 2'b10);
        drive(0, 0, DEPTH - 1, 0);
        txn(0, 0, DEPTH - 1, 0, 32'h5a, 0, 2'b01);
        drive(0, 0, DEPTH, 0);
        txn(0, 0, DEPTH, 0, 0, 1, 2'b01);
        drive(1, 0, 32'h8000_0000, 0);
        txn(1, 0, 32'h8000_0000, 0, 0, 1, 2'b10);

        // Reset during ACCESS of a write
        drive(0, 1, 2, 32'h11);
        txn(0, 1, 2, 32'h11, 0, 0, 2'b01);
        drive(0, 1, 2, 32'h77);
        #1;
        chk("mid_a_ready", aReqReady, 1'b1);
        @(posedge clk); #1;
        chk("mid_acc_we", memWriteEnable, 1'b1);
        aReqValid = 1'b0;
        reset_n   = 1'b0;
        #1;
        chk("mid_rst_we", memWriteEnable, 1'b0);
        chk("mid_rst_addr", memAddress, '0);
        @(posedge clk); #1;
        chk("mid_no_rsp_1", aRspValid | bRspValid, 1'b0);
        chk("mid_no_commit", mem[2], 32'h11);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_no_rsp_2", aRspValid | bRspValid, 1'b0);
        chk("mid_idle_ready", aReqReady, 1'b1);
        drive(0, 0, 2, 0);
        txn(0, 0, 2, 0, 32'h11, 0, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
